id_ex_skid: RTL and testbench

Parametrised ID→EX pipeline register with a valid/ready handshake, a one-entry skid buffer, flush support and a saturating back-pressure counter. It sits between decode and execute. It replaces the plain always-load ID/EX register so that execute can stall decode without a combinational ready path, and so that branch/exception logic can squash in-flight instructions.

---
 rtl/id_ex_pkg.sv | 38 +++
 rtl/id_ex_skid_if.sv | 54 +++++
 rtl/id_ex_skid_pipe_skid_buf.sv | 56 +++++
 rtl/id_ex_skid.sv | 63 ++++++
 tb/tb_id_ex_skid.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_pkg.sv
// Shared ID/EX definitions: default widths, payload bundle, ALU codes.
// Imported by decode, execute and the ID/EX skid register.
package id_ex_pkg;

    localparam int ID_EX_XLEN     = 64;
    localparam int ID_EX_ALUOP_W  = 8;
    localparam int ID_EX_ALUSEL_W = 4;
    localparam int ID_EX_RADDR_W  = 5;
    localparam int ID_EX_CNT_W    = 16;

    typedef struct packed {
        logic [ID_EX_ALUOP_W-1:0]  aluop;
        logic [ID_EX_ALUSEL_W-1:0] alusel;
        logic [ID_EX_XLEN-1:0]     op1;
        logic [ID_EX_XLEN-1:0]     op2;
        logic [ID_EX_RADDR_W-1:0]  rd;
        logic                      we;
        logic                      mem_valid;
        logic                      mem_rw;
    } id_ex_payload_t;

    localparam logic [ID_EX_ALUOP_W-1:0] ALUOP_NOP = 8'h00;
    localparam logic [ID_EX_ALUOP_W-1:0] ALUOP_ADD = 8'h20;
    localparam logic [ID_EX_ALUOP_W-1:0] ALUOP_SUB = 8'h22;
    localparam logic [ID_EX_ALUOP_W-1:0] ALUOP_AND = 8'h24;
    localparam logic [ID_EX_ALUOP_W-1:0] ALUOP_OR  = 8'h25;
    localparam logic [ID_EX_ALUOP_W-1:0] ALUOP_XOR = 8'h26;
    localparam logic [ID_EX_ALUOP_W-1:0] ALUOP_SLL = 8'h04;
    localparam logic [ID_EX_ALUOP_W-1:0] ALUOP_LD  = 8'h30;
    localparam logic [ID_EX_ALUOP_W-1:0] ALUOP_SD  = 8'h38;

    localparam logic [ID_EX_ALUSEL_W-1:0] ALUSEL_NOP   = 4'd0;
    localparam logic [ID_EX_ALUSEL_W-1:0] ALUSEL_LOGIC = 4'd1;
    localparam logic [ID_EX_ALUSEL_W-1:0] ALUSEL_SHIFT = 4'd2;
    localparam logic [ID_EX_ALUSEL_W-1:0] ALUSEL_ARITH = 4'd3;
    localparam logic [ID_EX_ALUSEL_W-1:0] ALUSEL_MEM   = 4'd4;

endpackage

// File: rtl/id_ex_skid_if.sv
// ID->EX handshake bundle: decode side drives *_i, the register drives *_o.
// master = decode/execute environment, slave = the ID/EX register.
interface id_ex_skid_if
    import id_ex_pkg::*;
#(
    parameter int XLEN     = ID_EX_XLEN,
    parameter int ALUOP_W  = ID_EX_ALUOP_W,
    parameter int ALUSEL_W = ID_EX_ALUSEL_W,
    parameter int RADDR_W  = ID_EX_RADDR_W,
    parameter int CNT_W    = ID_EX_CNT_W
);
    logic                valid_i;
    logic                ready_o;
    logic [ALUOP_W-1:0]  aluop_i;
    logic [ALUSEL_W-1:0] alusel_i;
    logic [XLEN-1:0]     oprand1_i;
    logic [XLEN-1:0]     oprand2_i;
    logic [RADDR_W-1:0]  reg_write_addr_i;
    logic                reg_write_enable_i;
    logic                mem_valid_i;
    logic                mem_rw_i;
    logic                flush_i;

    logic                valid_o;
    logic                ready_i;
    logic [ALUOP_W-1:0]  aluop_o;
    logic [ALUSEL_W-1:0] alusel_o;
    logic [XLEN-1:0]     oprand1_o;
    logic [XLEN-1:0]     oprand2_o;
    logic [RADDR_W-1:0]  reg_write_addr_o;
    logic                reg_write_enable_o;
    logic                mem_valid_o;
    logic                mem_rw_o;
    logic [CNT_W-1:0]    stall_cnt_o;

    modport master (
        output valid_i, aluop_i, alusel_i, oprand1_i, oprand2_i,
               reg_write_addr_i, reg_write_enable_i, mem_valid_i,
               mem_rw_i, flush_i, ready_i,
        input  ready_o, valid_o, aluop_o, alusel_o, oprand1_o,
               oprand2_o, reg_write_addr_o, reg_write_enable_o,
               mem_valid_o, mem_rw_o, stall_cnt_o
    );

    modport slave (
        input  valid_i, aluop_i, alusel_i, oprand1_i, oprand2_i,
               reg_write_addr_i, reg_write_enable_i, mem_valid_i,
               mem_rw_i, flush_i, ready_i,
        output ready_o, valid_o, aluop_o, alusel_o, oprand1_o,
               oprand2_o, reg_write_addr_o, reg_write_enable_o,
               mem_valid_o, mem_rw_o, stall_cnt_o
    );

endinterface

// File: rtl/id_ex_skid_pipe_skid_buf.sv
// Generic one-entry skid pipeline register with flush.
// ready is taken straight from the skid flop, never from i_ready.
module pipe_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);
    logic             r_main_v;
    logic             r_skid_v;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic w_accept;
    logic w_load;

    assign o_ready  = ~r_skid_v;
    assign w_accept = i_valid & ~r_skid_v & ~i_flush;
    assign w_load   = ~r_main_v | (r_main_v & i_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main   <= '0;
            r_skid   <= '0;
        end else if (i_flush) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (w_load) begin
            if (r_skid_v) begin
                // skid is older than anything arriving now
                r_main   <= r_skid;
                r_main_v <= 1'b1;
                r_skid_v <= 1'b0;
            end else begin
                r_main_v <= w_accept;
                if (w_accept) r_main <= i_data;
            end
        end else if (w_accept) begin
            r_skid   <= i_data;
            r_skid_v <= 1'b1;
        end
    end

    assign o_valid = r_main_v;
    assign o_data  = r_main;

endmodule

// File: rtl/id_ex_skid.sv
// ID->EX pipeline register: skid buffer on the packed payload,
// valid-gated write/mem controls and a saturating stall counter.
module id_ex_skid
    import id_ex_pkg::*;
#(
    parameter int XLEN     = ID_EX_XLEN,
    parameter int ALUOP_W  = ID_EX_ALUOP_W,
    parameter int ALUSEL_W = ID_EX_ALUSEL_W,
    parameter int RADDR_W  = ID_EX_RADDR_W,
    parameter int CNT_W    = ID_EX_CNT_W
) (
    input logic         clk,
    input logic         rst,
    id_ex_skid_if.slave bus
);
    localparam int W = ALUOP_W + ALUSEL_W + 2 * XLEN + RADDR_W + 3;

    logic [W-1:0]     w_in;
    logic [W-1:0]     w_out;
    logic             w_main_v;
    logic             w_we;
    logic             w_mem_v;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_in = {bus.aluop_i, bus.alusel_i,
                   bus.oprand1_i, bus.oprand2_i,
                   bus.reg_write_addr_i, bus.reg_write_enable_i,
                   bus.mem_valid_i, bus.mem_rw_i};

    pipe_skid_buf #(.WIDTH(W)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_valid (bus.valid_i),
        .o_ready (bus.ready_o),
        .i_data  (w_in),
        .i_flush (bus.flush_i),
        .o_valid (w_main_v),
        .i_ready (bus.ready_i),
        .o_data  (w_out)
    );

    assign {bus.aluop_o, bus.alusel_o,
            bus.oprand1_o, bus.oprand2_o,
            bus.reg_write_addr_o, w_we,
            w_mem_v, bus.mem_rw_o} = w_out;

    // bubbles must never write the register file or touch memory
    assign bus.valid_o            = w_main_v;
    assign bus.reg_write_enable_o = w_main_v & w_we;
    assign bus.mem_valid_o        = w_main_v & w_mem_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_main_v & ~bus.ready_i & ~bus.flush_i
                     & ~(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_skid.sv
// Scoreboard bench for id_ex_skid: directed stimulus, queued expectations,
// independent output monitor, plus a narrow-counter saturation instance.
module tb_id_ex_skid;
    import id_ex_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_ex_skid_if b ();
    id_ex_skid_if #(.CNT_W(4)) b2 ();

    id_ex_skid u_dut (.clk(clk), .rst(rst), .bus(b));
    id_ex_skid #(.CNT_W(4)) u_sat (.clk(clk), .rst(rst), .bus(b2));

    int vectors = 0;
    int miscompares = 0;
    id_ex_payload_t sb[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic id_ex_payload_t mk(input logic [7:0] op,
                                          input logic [3:0] sel,
                                          input logic [63:0] a,
                                          input logic [63:0] c,
                                          input logic [4:0] rd,
                                          input logic we,
                                          input logic mv,
                                          input logic rw);
        id_ex_payload_t p;
        p.aluop = op; p.alusel = sel; p.op1 = a; p.op2 = c;
        p.rd = rd; p.we = we; p.mem_valid = mv; p.mem_rw = rw;
        return p;
    endfunction

    task automatic drive(input logic v, input id_ex_payload_t p,
                         input logic rdy, input logic fl);
        b.valid_i            = v;
        b.aluop_i            = p.aluop;
        b.alusel_i           = p.alusel;
        b.oprand1_i          = p.op1;
        b.oprand2_i          = p.op2;
        b.reg_write_addr_i   = p.rd;
        b.reg_write_enable_i = p.we;
        b.mem_valid_i        = p.mem_valid;
        b.mem_rw_i           = p.mem_rw;
        b.ready_i            = rdy;
        b.flush_i            = fl;
    endtask

    task automatic step(input logic v, input id_ex_payload_t p,
                        input logic rdy, input logic fl);
        drive(v, p, rdy, fl);
        @(negedge clk);
        if (v && b.ready_o && !fl && !rst) sb.push_back(p);
        @(posedge clk);
        #1;
    endtask

    // monitor: one comparison per transfer seen at the outputs
    always begin
        id_ex_payload_t exp_p;
        id_ex_payload_t act_p;
        @(negedge clk);
        #1;
        if (rst) begin
        end else if (b.flush_i) begin
            sb.delete();
        end else if (b.valid_o && b.ready_i) begin
            vectors++;
            act_p = {b.aluop_o, b.alusel_o, b.oprand1_o, b.oprand2_o,
                     b.reg_write_addr_o, b.reg_write_enable_o,
                     b.mem_valid_o, b.mem_rw_o};
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL xfer_unexpected: got %h expected none", act_p);
            end else begin
                exp_p = sb.pop_front();
                if (act_p !== exp_p) begin
                    miscompares++;
                    $display("FAIL xfer: got %h expected %h", act_p, exp_p);
                end
            end
        end
    end

    id_ex_payload_t pA, pB, pC, pD, pE, pF, pG, pH, pI, pJ;
    id_ex_payload_t pK, pL, pM, pQ, pN, pO, pP, pZ;

    initial begin
        pA = mk(ALUOP_ADD, ALUSEL_ARITH, 64'h1111_0000_0000_0001, 64'h2, 5'd1, 1, 0, 0);
        pB = mk(ALUOP_SUB, ALUSEL_ARITH, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3, 5'd2, 1, 0, 0);
        pC = mk(ALUOP_AND, ALUSEL_LOGIC, 64'hA5A5_A5A5_A5A5_A5A5, 64'hF0F0, 5'd3, 1, 0, 0);
        pD = mk(ALUOP_LD,  ALUSEL_MEM,   64'h8000_0000, 64'h10, 5'd4, 1, 1, 0);
        pE = mk(ALUOP_OR,  ALUSEL_LOGIC, 64'h5, 64'h6, 5'd5, 1, 0, 0);
        pF = mk(ALUOP_SD,  ALUSEL_MEM,   64'h8000_0040, 64'hDEAD_BEEF, 5'd0, 0, 1, 1);
        pG = mk(ALUOP_XOR, ALUSEL_LOGIC, 64'h7, 64'h7, 5'd7, 1, 0, 0);
        pH = mk(ALUOP_SLL, ALUSEL_SHIFT, 64'h1, 64'h3F, 5'd8, 1, 0, 0);
        pI = mk(ALUOP_ADD, ALUSEL_ARITH, 64'h9, 64'h9, 5'd9, 1, 0, 0);
        pJ = mk(ALUOP_SUB, ALUSEL_ARITH, 64'hA, 64'hA, 5'd10, 1, 1, 1);
        pK = mk(ALUOP_AND, ALUSEL_LOGIC, 64'hB, 64'hB, 5'd11, 1, 0, 0);
        pL = mk(ALUOP_OR,  ALUSEL_LOGIC, 64'hC, 64'hC, 5'd12, 1, 0, 0);
        pM = mk(ALUOP_LD,  ALUSEL_MEM,   64'hD, 64'hD, 5'd13, 1, 1, 0);
        pQ = mk(ALUOP_SD,  ALUSEL_MEM,   64'hE, 64'hE, 5'd14, 1, 1, 1);
        pN = mk(ALUOP_XOR, ALUSEL_LOGIC, 64'hF, 64'hF, 5'd15, 1, 0, 0);
        pO = mk(ALUOP_ADD, ALUSEL_ARITH, 64'h10, 64'h10, 5'd16, 1, 0, 0);
        pP = mk(ALUOP_SUB, ALUSEL_ARITH, 64'h1234_5678_9ABC_DEF0, 64'h11, 5'd17, 1, 0, 0);
        pZ = '0;

        drive(1'b0, pZ, 1'b0, 1'b0);
        b2.valid_i = 0; b2.aluop_i = '0; b2.alusel_i = '0;
        b2.oprand1_i = '0; b2.oprand2_i = '0; b2.reg_write_addr_i = '0;
        b2.reg_write_enable_i = 0; b2.mem_valid_i = 0; b2.mem_rw_i = 0;
        b2.flush_i = 0; b2.ready_i = 1;

        @(posedge clk);
        #1;
        chk("rst_valid_o", longint'(b.valid_o), 0);
        chk("rst_ready_o", longint'(b.ready_o), 1);
        chk("rst_we_o", longint'(b.reg_write_enable_o), 0);
        chk("rst_memv_o", longint'(b.mem_valid_o), 0);
        chk("rst_stall", longint'(b.stall_cnt_o), 0);
        chk("rst_aluop_o", longint'(b.aluop_o), 0);
        rst = 1'b0;

        // back-to-back at full rate
        step(1, pA, 1, 0);
        chk("b2b_valid_lat1", longint'(b.valid_o), 1);
        chk("b2b_ready", longint'(b.ready_o), 1);
        step(1, pB, 1, 0);
        step(1, pC, 1, 0);
        step(1, pD, 1, 0);
        chk("b2b_ready_end", longint'(b.ready_o), 1);
        chk("b2b_op1_D", longint'(b.oprand1_o), 64'h8000_0000);
        step(0, pZ, 1, 0);
        chk("b2b_stall", longint'(b.stall_cnt_o), 0);
        chk("b2b_drained", longint'(b.valid_o), 0);

        // three stall cycles with decode pushing
        step(1, pE, 1, 0);
        step(1, pF, 0, 0);
        chk("stall_ready_drop", longint'(b.ready_o), 0);
        step(1, pG, 0, 0);
        step(1, pG, 0, 0);
        chk("stall_cnt3", longint'(b.stall_cnt_o), 3);
        chk("stall_hold_rd", longint'(b.reg_write_addr_o), 5);
        step(1, pG, 1, 0);
        chk("stall_ready_rise", longint'(b.ready_o), 1);
        chk("stall_main_F", longint'(b.oprand2_o), 64'hDEAD_BEEF);
        step(1, pG, 1, 0);
        step(0, pZ, 1, 0);
        chk("stall_cnt_hold", longint'(b.stall_cnt_o), 3);

        // flush with main and skid full
        step(1, pH, 0, 0);
        step(1, pI, 0, 0);
        chk("pre_flush_ready", longint'(b.ready_o), 0);
        step(1, pJ, 1, 1);
        chk("flush_valid_o", longint'(b.valid_o), 0);
        chk("flush_ready_o", longint'(b.ready_o), 1);
        chk("flush_we_o", longint'(b.reg_write_enable_o), 0);
        chk("flush_memv_o", longint'(b.mem_valid_o), 0);

        // flush discards an otherwise acceptable input
        step(1, pK, 0, 0);
        step(1, pL, 0, 1);
        chk("flush2_valid_o", longint'(b.valid_o), 0);
        chk("flush_no_count", longint'(b.stall_cnt_o), 4);
        step(1, pM, 1, 0);

        // bubble keeps stale we/mem_valid gated off
        step(0, pQ, 1, 0);
        chk("bubble_valid_o", longint'(b.valid_o), 0);
        chk("bubble_we_o", longint'(b.reg_write_enable_o), 0);
        chk("bubble_memv_o", longint'(b.mem_valid_o), 0);

        // reset while skid is full
        step(1, pN, 0, 0);
        step(1, pO, 0, 0);
        chk("prerst_ready", longint'(b.ready_o), 0);
        chk("prerst_stall", longint'(b.stall_cnt_o), 5);
        #3;
        rst = 1'b1;
        #1;
        sb.delete();
        chk("arst_valid_o", longint'(b.valid_o), 0);
        chk("arst_ready_o", longint'(b.ready_o), 1);
        chk("arst_stall", longint'(b.stall_cnt_o), 0);
        chk("arst_we_o", longint'(b.reg_write_enable_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, pP, 1, 0);
        chk("postrst_valid", longint'(b.valid_o), 1);
        step(0, pZ, 1, 0);
        chk("sb_empty", longint'(sb.size()), 0);

        // narrow counter saturation
        b2.valid_i = 1;
        b2.ready_i = 0;
        repeat (16) @(posedge clk);
        #1;
        chk("sat_reach15", longint'(b2.stall_cnt_o), 15);
        repeat (20) @(posedge clk);
        #1;
        chk("sat_hold15", longint'(b2.stall_cnt_o), 15);
        chk("sat_valid", longint'(b2.valid_o), 1);
        b2.valid_i = 0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
